// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//   Receive end of a multiplexed, active-low 7-segment bus. Each scanned
//   digit is sampled once its anode/segment pattern has been stable for
//   STABLE_CYCLES cycles. The pattern is decoded back to BCD, with 4'hF
//   standing for an unknown glyph. A watchdog ages out every digit when no
//   capture has happened for TIMEOUT cycles.
//
//   Ports
//     clk, rst_n    rising-edge clock, async active-low reset
//     seg_in[6:0]   segments, active-low, bit6=g .. bit0=a
//     an_in         anode selects, active-low, one bit per digit
//     digits_out    digit i BCD at [4i+3:4i] (4'hF = illegal glyph)
//     digit_valid   digit i holds a legal capture that has not aged out
//     update        1-cycle pulse, legal digit captured
//     pat_err       1-cycle pulse, illegal pattern captured
//     stale         level, TIMEOUT cycles have passed since the last capture

// Per-digit storage. A write always wins over the watchdog clear.
module seg_scan_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [3:0] code,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'h0;
            valid <= 1'b0;
        end else if (wr) begin
            digit <= code;
            valid <= (code != 4'hF);
        end else if (clr) begin
            valid <= 1'b0;
        end
    end
endmodule

module seg_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT       = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  pat_err,
    output logic                  stale
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
    } sample_t;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    sample_t                   s1, s2;
    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [WW-1:0]             wd;
    logic                      same, sel_ok, cap, wd_hit;
    logic [3:0]                code;
    logic [DIGITS-1:0][3:0]    dig_q;

    function automatic logic [3:0] glyph2bcd(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction

    // Exactly one anode low: the inverted vector is a non-zero power of two.
    function automatic logic one_cold(input logic [DIGITS-1:0] an);
        logic [DIGITS-1:0] z;
        z = ~an;
        return (z != '0) && ((z & (z - DIGITS'(1))) == '0);
    endfunction

    assign same   = (s1 == s2);
    assign sel_ok = one_cold(s1.an);
    assign code   = glyph2bcd(s1.seg);
    // Capture on the edge that would take cnt to STABLE_CYCLES; a change in
    // that same cycle drops into the restart path instead.
    assign cap    = (state == SETTLE) && same && (cnt == CW'(STABLE_CYCLES - 1));
    assign wd_hit = !cap && (wd == WW'(TIMEOUT - 1));

    // Input register stage plus one cycle of history. Reset to "nothing
    // selected" so the first legal sample after reset is seen as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= sample_t'({an_in, seg_in});
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            update  <= 1'b0;
            pat_err <= 1'b0;
        end else begin
            update  <= 1'b0;
            pat_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_ok) begin
                        state <= SETTLE;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                SETTLE, CAPTURED: begin
                    if (!same) begin
                        if (sel_ok) begin
                            state <= SETTLE;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (cap) begin
                        state   <= CAPTURED;
                        cnt     <= cnt + CW'(1);
                        update  <= (code != 4'hF);
                        pat_err <= (code == 4'hF);
                    end else if (state == SETTLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Watchdog counts cycles since the last capture and saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd    <= '0;
            stale <= 1'b0;
        end else if (cap) begin
            wd    <= '0;
            stale <= 1'b0;
        end else if (wd_hit) begin
            wd    <= WW'(TIMEOUT);
            stale <= 1'b1;
        end else if (wd != WW'(TIMEOUT)) begin
            wd <= wd + WW'(1);
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        seg_scan_digit u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (cap && !s1.an[i]),
            .code  (code),
            .clr   (wd_hit),
            .digit (dig_q[i]),
            .valid (digit_valid[i])
        );
    end

    assign digits_out = dig_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
module tb_seg_scan_reader;
    localparam int DIGITS  = 4;
    localparam int S       = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        update, pat_err, stale;

    int n_chk = 0;
    int n_fail = 0;

    seg_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .update      (update),
        .pat_err     (pat_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
        7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000};

    // Reference model: a capture happens at the edge where the last S samples
    // are identical with a legal selection, and the sample before them differs
    // (so one capture per stable run).
    logic [10:0] hist [S+1];
    bit          hv   [S+1];
    int          n_edge, last_cap;
    logic [3:0]  m_dig [DIGITS];
    bit          m_val [DIGITS];
    bit          m_upd, m_err, m_stale;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] g_code(input logic [6:0] seg);
        for (int k = 0; k < 10; k++)
            if (seg == GLYPH[k]) return 4'(k);
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= S; i++) begin hist[i] = '0; hv[i] = 0; end
        for (int i = 0; i < DIGITS; i++) begin m_dig[i] = 0; m_val[i] = 0; end
        n_edge = 0; last_cap = 0;
        m_upd = 0; m_err = 0; m_stale = 0;
    endtask

    task automatic model_step();
        bit          cap;
        logic [10:0] cur;
        logic [3:0]  c;
        int          d;
        cur = hist[0];
        n_edge++;
        cap = hv[0] && ($countones(cur[10:7]) == DIGITS - 1);
        for (int i = 1; i < S; i++)
            if (!hv[i] || hist[i] !== cur) cap = 0;
        if (hv[S] && hist[S] === cur) cap = 0;
        m_upd = 0; m_err = 0;
        if (cap) begin
            d = 0;
            for (int i = 0; i < DIGITS; i++) if (!cur[7+i]) d = i;
            c = g_code(cur[6:0]);
            m_dig[d] = c;
            m_val[d] = (c != 4'hF);
            m_upd = (c != 4'hF);
            m_err = (c == 4'hF);
            last_cap = n_edge;
        end else if (n_edge - last_cap == TIMEOUT) begin
            for (int i = 0; i < DIGITS; i++) m_val[i] = 0;
        end
        m_stale = (n_edge - last_cap >= TIMEOUT);
        for (int i = S; i > 0; i--) begin hist[i] = hist[i-1]; hv[i] = hv[i-1]; end
        hist[0] = {an_in, seg_in};
        hv[0] = 1;
    endtask

    task automatic compare_model();
        logic [15:0] ed;
        logic [3:0]  ev;
        for (int i = 0; i < DIGITS; i++) begin
            ed[4*i +: 4] = m_dig[i];
            ev[i] = m_val[i];
        end
        check("digits", 32'(digits_out), 32'(ed));
        check("valid", 32'(digit_valid), 32'(ev));
        check("update", 32'(update), 32'(m_upd));
        check("pat_err", 32'(pat_err), 32'(m_err));
        check("stale", 32'(stale), 32'(m_stale));
    endtask

    // One clock: model advances with the DUT edge, outputs compared at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        an_in = an;
        seg_in = seg;
    endtask

    int k, first, nupd, nerr;
    logic [15:0] dsnap;

    initial begin
        model_reset();
        tick();
        tick();
        check("rst_digits", 32'(digits_out), 32'h0);
        check("rst_flags", 32'({update, pat_err, stale, digit_valid}), 32'h0);
        rst_n = 1'b1;

        // Reset while settling, then release with inputs held.
        drive(4'b1110, GLYPH[2]);
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("midrst_digits", 32'(digits_out), 32'h0);
        check("midrst_flags", 32'({update, pat_err, stale, digit_valid}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (update && first < 0) first = i;
        end
        check("first_update_cycle", 32'(first), 32'd9);
        dsnap = digits_out;
        check("digit0_is_2", 32'(dsnap[3:0]), 32'd2);
        check("valid_0001", 32'(digit_valid), 32'b0001);

        // Scan 1,9,0,7 on digits 0..3, two passes.
        for (int p = 0; p < 2; p++) begin
            nupd = 0;
            for (int d = 0; d < 4; d++) begin
                drive(~(4'b1 << d), (d == 0) ? GLYPH[1] : (d == 1) ? GLYPH[9] :
                                    (d == 2) ? GLYPH[0] : GLYPH[7]);
                for (int i = 0; i < 16; i++) begin tick(); nupd += int'(update); end
            end
            check("scan_updates", 32'(nupd), 32'd4);
            check("scan_digits", 32'(digits_out), 32'h7091);
            check("scan_valid", 32'(digit_valid), 32'hF);
        end

        // Blank glyph on digit 2.
        drive(4'b1011, 7'h7F);
        nerr = 0; nupd = 0;
        for (int i = 0; i < 16; i++) begin
            tick(); nerr += int'(pat_err); nupd += int'(update);
        end
        check("blank_perr", 32'(nerr), 32'd1);
        check("blank_upd", 32'(nupd), 32'd0);
        check("blank_digits", 32'(digits_out), 32'h7F91);
        check("blank_valid", 32'(digit_valid), 32'b1011);

        // Two anodes low, then a glyph toggling faster than the settle time.
        drive(4'b1100, GLYPH[8]);
        nupd = 0;
        for (int i = 0; i < 24; i++) begin tick(); nupd += int'(update) + int'(pat_err); end
        for (int t = 0; t < 4; t++) begin
            drive(4'b1110, t[0] ? GLYPH[5] : GLYPH[3]);
            for (int i = 0; i < 7; i++) begin tick(); nupd += int'(update) + int'(pat_err); end
        end
        check("no_capture", 32'(nupd), 32'd0);

        // Watchdog: stop scanning after a capture.
        drive(4'b1110, GLYPH[4]);
        k = 0;
        do begin tick(); k++; end while (!update && k < 20);
        check("wd_cap", 32'(update), 32'd1);
        drive(4'hF, 7'h7F);
        k = 0;
        while (!stale && k < 100) begin tick(); k++; end
        check("stale_delay", 32'(k), 32'd64);
        check("stale_valid", 32'(digit_valid), 32'h0);
        drive(4'b1110, GLYPH[1]);
        k = 0;
        do begin tick(); k++; end while (!update && k < 20);
        check("stale_cap", 32'(update), 32'd1);
        check("stale_cleared", 32'(stale), 32'd0);
        // Next capture lands exactly on the timeout edge.
        drive(4'hF, 7'h7F);
        for (int i = 0; i < 55; i++) tick();
        drive(4'b1101, GLYPH[9]);
        for (int i = 0; i < 9; i++) tick();
        check("tie_update", 32'(update), 32'd1);
        check("tie_stale", 32'(stale), 32'd0);
        check("tie_valid", 32'(digit_valid), 32'b0011);

        // Random stimulus against the model.
        for (int n = 0; n < 260; n++) begin
            int r, len;
            r = $urandom_range(0, 99);
            len = $urandom_range(1, 20);
            if (r < 2) begin
                rst_n = 1'b0;
                #1 model_reset();
                tick();
                rst_n = 1'b1;
                continue;
            end
            r = $urandom_range(0, 99);
            if (r < 70) an_in = ~(4'b1 << $urandom_range(0, 3));
            else if (r < 85) an_in = 4'hF;
            else an_in = 4'($urandom);
            r = $urandom_range(0, 99);
            if (r < 60) seg_in = GLYPH[$urandom_range(0, 9)];
            else if (r < 75) seg_in = 7'h7F;
            else seg_in = 7'($urandom);
            if ($urandom_range(0, 99) < 8) begin
                an_in = 4'hF;
                len = $urandom_range(50, 80);
            end
            for (int i = 0; i < len; i++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
